// File: rtl/msrv32_integer_file_pkg.sv
// Shared constants for the RV32I integer register file and its neighbours
// (write-enable generator, operand stage).
package msrv32_integer_file_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;

  // Architectural zero register index (x0).
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/msrv32_rf_read_port.sv
// One asynchronous read port: x0 forcing, write-first bypass and output mux.
module msrv32_rf_read_port #(
  parameter int XLEN   = msrv32_integer_file_pkg::XLEN,
  parameter int ADDR_W = msrv32_integer_file_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_wr_valid,    // qualified write: enabled, out of reset, rd != x0, rd in range
  input  logic [XLEN-1:0]   i_rd_data,
  input  logic [XLEN-1:0]   i_stored_data, // array contents at i_rs_addr (0 for absent registers)
  output logic [XLEN-1:0]   o_rs_data
);

  import msrv32_integer_file_pkg::*;

  logic w_is_zero;
  logic w_bypass;

  assign w_is_zero = (i_rs_addr == ADDR_W'(ZERO_REG));
  assign w_bypass  = i_wr_valid && (i_rs_addr == i_rd_addr);

  // Select zero for x0, the retiring value on an address match, else stored data.
  always_comb begin
    o_rs_data = i_stored_data;
    if (w_is_zero) begin
      o_rs_data = '0;
    end else if (w_bypass) begin
      o_rs_data = i_rd_data;
    end
  end

endmodule

// File: rtl/msrv32_integer_file.sv
// RV32I integer register file: two combinational read ports with write-first
// bypass, one synchronous write port, x0 hardwired to zero, async clear.
module msrv32_integer_file #(
  parameter int XLEN      = msrv32_integer_file_pkg::XLEN,
  parameter int REG_COUNT = msrv32_integer_file_pkg::REG_COUNT,
  parameter int ADDR_W    = msrv32_integer_file_pkg::ADDR_W
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [ADDR_W-1:0] rs_1_addr_in,
  input  logic [ADDR_W-1:0] rs_2_addr_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              wr_en_in,
  input  logic [XLEN-1:0]   rd_in,
  output logic [XLEN-1:0]   rs_1_out,
  output logic [XLEN-1:0]   rs_2_out
);

  import msrv32_integer_file_pkg::*;

  // Every encodable address gets a slot so reads never index out of range;
  // slots beyond REG_COUNT (and x0) are constant zero.
  localparam int NUM_ADDR = 1 << ADDR_W;

  logic [XLEN-1:0]     w_regs [0:NUM_ADDR-1];
  logic [NUM_ADDR-1:0] w_in_range;
  logic                w_wr_valid;
  logic [XLEN-1:0]     w_rs_1_stored;
  logic [XLEN-1:0]     w_rs_2_stored;

  // A write (and hence a bypass) only counts when out of reset, aimed at a
  // real register other than x0.
  assign w_wr_valid = wr_en_in && ms_riscv32_mp_rst_in &&
                      (rd_addr_in != ADDR_W'(ZERO_REG)) && w_in_range[rd_addr_in];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ADDR; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_regs[gi]     = '0;
        assign w_in_range[gi] = 1'b1;
      end else if (gi < REG_COUNT) begin : g_store
        logic [XLEN-1:0] r_data;
        logic            w_we;

        assign w_we = w_wr_valid && (rd_addr_in == ADDR_W'(gi));

        // Register storage: cleared immediately on reset, loaded on its address match.
        always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
          if (!ms_riscv32_mp_rst_in) begin
            r_data <= '0;
          end else if (w_we) begin
            r_data <= rd_in;
          end
        end

        assign w_regs[gi]     = r_data;
        assign w_in_range[gi] = 1'b1;
      end else begin : g_absent
        assign w_regs[gi]     = '0;
        assign w_in_range[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_rs_1_stored = w_regs[rs_1_addr_in];
  assign w_rs_2_stored = w_regs[rs_2_addr_in];

  msrv32_rf_read_port #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_read_port_1 (
    .i_rs_addr     (rs_1_addr_in),
    .i_rd_addr     (rd_addr_in),
    .i_wr_valid    (w_wr_valid),
    .i_rd_data     (rd_in),
    .i_stored_data (w_rs_1_stored),
    .o_rs_data     (rs_1_out)
  );

  msrv32_rf_read_port #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_read_port_2 (
    .i_rs_addr     (rs_2_addr_in),
    .i_rd_addr     (rd_addr_in),
    .i_wr_valid    (w_wr_valid),
    .i_rd_data     (rd_in),
    .i_stored_data (w_rs_2_stored),
    .o_rs_data     (rs_2_out)
  );

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed bench for msrv32_integer_file with an expected-value scoreboard.
module tb_msrv32_integer_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_1_addr;
  logic [4:0]  rs_2_addr;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [31:0] rd_data;
  logic [31:0] rs_1_data;
  logic [31:0] rs_2_data;

  typedef struct packed {
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  msrv32_integer_file dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .rs_1_addr_in         (rs_1_addr),
    .rs_2_addr_in         (rs_2_addr),
    .rd_addr_in           (rd_addr),
    .wr_en_in             (wr_en),
    .rd_in                (rd_data),
    .rs_1_out             (rs_1_data),
    .rs_2_out             (rs_2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus on the falling edge, record the expected
  // read data, then compare the combinational outputs 1 time unit later.
  task automatic apply(input string tag, input logic rst, input logic we,
                       input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2);
    exp_t exp_item;
    exp_t got;
    @(negedge clk);
    rst_n     = rst;
    wr_en     = we;
    rd_addr   = rd;
    rd_data   = d;
    rs_1_addr = a1;
    rs_2_addr = a2;
    exp_item.e1 = e1;
    exp_item.e2 = e2;
    sb_q.push_back(exp_item);
    #1;
    got = sb_q.pop_front();
    total++;
    assert (rs_1_data === got.e1) else begin
      bad++;
      $error("FAIL %s rs_1_out observed=%h expected=%h", tag, rs_1_data, got.e1);
    end
    total++;
    assert (rs_2_data === got.e2) else begin
      bad++;
      $error("FAIL %s rs_2_out observed=%h expected=%h", tag, rs_2_data, got.e2);
    end
    $display("txn %s rst=%0b we=%0b rd=%0d d=%h rs1=%0d:%h rs2=%0d:%h",
             tag, rst, we, rd, d, a1, rs_1_data, a2, rs_2_data);
  endtask

  function automatic logic [31:0] sweep_val(input int idx);
    logic [31:0] v;
    v = (idx == 0) ? 32'h0 : (32'(idx) * 32'h01010101);
    return v;
  endfunction

  initial begin
    rst_n     = 1'b1;
    wr_en     = 1'b0;
    rd_addr   = '0;
    rd_data   = '0;
    rs_1_addr = '0;
    rs_2_addr = '0;
    #2 rst_n  = 1'b0;

    // Reset: bypass gated off, write presented during reset is lost
    apply("reset_gated_bypass", 1'b0, 1'b1, 5'd5, 32'h00001234, 5'd5, 5'd6, 32'h0, 32'h0);
    apply("reset_write_lost",   1'b1, 1'b0, 5'd0, 32'h0,        5'd5, 5'd31, 32'h0, 32'h0);

    // Reset mid-run after writing x5
    apply("x5_bypass",          1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
    apply("x5_read",            1'b1, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    apply("reset_mid_async",    1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'h0, 32'h0);
    apply("reset_mid_release",  1'b1, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'h0, 32'h0);

    // Basic write then read on both ports
    apply("x10_write",          1'b1, 1'b1, 5'd10, 32'h12345678, 5'd0, 5'd0, 32'h0, 32'h0);
    apply("x10_read",           1'b1, 1'b0, 5'd0,  32'h0,        5'd10, 5'd10, 32'h12345678, 32'h12345678);

    // x0 immunity, including no bypass onto x0
    apply("x0_write",           1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0);
    apply("x0_after",           1'b1, 1'b0, 5'd0, 32'h0,        5'd0, 5'd10, 32'h0, 32'h12345678);

    // Bypass on port 1 only; port 2 sees old x8
    apply("x7_init",            1'b1, 1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0, 32'h0, 32'h0);
    apply("x8_init",            1'b1, 1'b1, 5'd8, 32'h88880008, 5'd7, 5'd0, 32'h00000001, 32'h0);
    apply("x7_bypass",          1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd8, 32'hA5A5A5A5, 32'h88880008);
    apply("x7_after",           1'b1, 1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 32'hA5A5A5A5, 32'h88880008);

    // Flushed write: no update, no bypass
    apply("x3_init",            1'b1, 1'b1, 5'd3, 32'h33333333, 5'd0, 5'd0, 32'h0, 32'h0);
    apply("x3_flushed",         1'b1, 1'b0, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3, 32'h33333333, 32'h33333333);
    apply("x3_keep",            1'b1, 1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 32'h33333333, 32'h0);

    // Both ports bypass at once
    apply("dual_bypass",        1'b1, 1'b1, 5'd9, 32'h13579BDF, 5'd9, 5'd9, 32'h13579BDF, 32'h13579BDF);

    // Full sweep: write x1..x31 (checking bypass), then read pairs
    for (int i = 1; i < 32; i++) begin
      apply($sformatf("sweep_wr_x%0d", i), 1'b1, 1'b1, 5'(i), sweep_val(i),
            5'(i), 5'd0, sweep_val(i), 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      int j;
      j = (i + 13) % 32;
      apply($sformatf("sweep_rd_x%0d_x%0d", i, j), 1'b1, 1'b0, 5'd0, 32'h0,
            5'(i), 5'(j), sweep_val(i), sweep_val(j));
    end

    // Final reset with a write pending clears everything
    apply("final_reset",        1'b0, 1'b1, 5'd4, 32'h00000077, 5'd4, 5'd4, 32'h0, 32'h0);
    apply("final_release",      1'b1, 1'b0, 5'd0, 32'h0,        5'd4, 5'd20, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msrv32_integer_file.md
Name: msrv32_integer_file

Overview:
- RV32I architectural integer register file (x0..x31). Sits in the writeback stage, directly downstream of the write-enable generator.
- Consumes the flush-qualified integer write enable plus writeback destination/data.
- Serves the two source-operand reads for the decode/operand stage.
- Two asynchronous read ports, one synchronous write port, write-to-read bypass, x0 hardwired to zero.

Parameters:
XLEN, 32, data width of each register
REG_COUNT, 32, number of architectural registers (x0..x31)
ADDR_W, 5, register address width (log2 REG_COUNT)

Ports:
ms_riscv32_mp_clk_in  input  1  system clock, all state updates on rising edge
ms_riscv32_mp_rst_in  input  1  asynchronous, active-low reset (0 = reset asserted)
rs_1_addr_in  input  ADDR_W  source register 1 index
rs_2_addr_in  input  ADDR_W  source register 2 index
rd_addr_in  input  ADDR_W  destination register index from writeback stage
wr_en_in  input  1  integer write enable from write-enable generator (already flush-qualified)
rd_in  input  XLEN  writeback data
rs_1_out  output  XLEN  operand 1 read data
rs_2_out  output  XLEN  operand 2 read data

Behaviour:
- Reset: on ms_riscv32_mp_rst_in falling to 0, all REG_COUNT registers clear to 0 immediately, without waiting for a clock edge. They stay 0 while reset is held low. rs_1_out and rs_2_out therefore read 0 during reset.
- Reset deassertion: the first write can occur on the first rising clock edge where ms_riscv32_mp_rst_in = 1.
- Write: on rising clock, if wr_en_in = 1 and rd_addr_in != 0, then reg[rd_addr_in] <= rd_in. Write latency is one edge.
- Writes to x0 are discarded; reg[0] is constant 0 and need not be physically stored.
- wr_en_in = 0: no register changes, regardless of rd_addr_in or rd_in.
- Read: combinational, zero latency. rs_n_out = 0 if rs_n_addr_in = 0; otherwise rs_n_out = reg[rs_n_addr_in].
- Bypass (write-first): if wr_en_in = 1, rd_addr_in != 0 and rs_n_addr_in = rd_addr_in, then rs_n_out = rd_in in the same cycle. This is required so the operand stage sees the value being retired without a stall.
  - Bypass applies to both ports independently.
  - Both ports may bypass simultaneously when both addresses match.
- Bypass never applies to x0. Reading x0 while writing x0 returns 0.
- Reset has priority over write. A write presented in the same cycle reset is asserted is lost.
- Bypass is gated by reset: while reset is asserted, outputs are 0 even if wr_en_in = 1.
- No X propagation: addresses are full-range (0..31) for REG_COUNT = 32, so no out-of-range handling is needed. For smaller REG_COUNT, out-of-range reads return 0 and out-of-range writes are ignored.
- Both reads and one write complete every cycle. The block has no internal stall or busy state.

Decomposition:
- Shared package / include: XLEN, REG_COUNT, ADDR_W, and the constant ZERO_REG = 5'd0. The write-enable generator and the operand stage use the same constants.
- One natural sub-module: msrv32_rf_read_port, instantiated twice. It holds the address-zero check, the bypass compare and the output mux, so both ports share identical logic.
- The storage array and write logic stay in the top.

Test Plan:
- Reset mid-run: write x5 = 32'hDEADBEEF, then pulse ms_riscv32_mp_rst_in low between clock edges -> rs_1_out reads 0 for x5 immediately and after reset releases.
- Basic write/read: wr_en_in = 1, rd_addr_in = 10, rd_in = 32'h12345678; next cycle rs_1_addr_in = 10, rs_2_addr_in = 10 -> both outputs are 32'h12345678.
- x0 immunity: wr_en_in = 1, rd_addr_in = 0, rd_in = 32'hFFFFFFFF -> rs_1_out with rs_1_addr_in = 0 is 0 in the same cycle and all later cycles.
- Bypass: reg x7 = 32'h1 stored; in one cycle wr_en_in = 1, rd_addr_in = 7, rd_in = 32'hA5A5A5A5, rs_1_addr_in = 7, rs_2_addr_in = 8 -> rs_1_out = 32'hA5A5A5A5 combinationally, rs_2_out = old x8.
- Flushed write: wr_en_in = 0, rd_addr_in = 3, rd_in = 32'hCAFEF00D -> x3 keeps its prior value and no bypass occurs.
- Full sweep: write x1..x31 with value (index × 32'h01010101), then read all pairs -> every readback matches and x0 = 0.
